// File: rtl/distortion_pkg.sv
// Shared types and constants for the distortion parameter sequencer.
package distortion_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRamp,
    StFadeOut,
    StSwitch,
    StFadeIn
  } state_e;

  localparam logic [1:0] SEL_GAIN   = 2'd0;
  localparam logic [1:0] SEL_THRESH = 2'd1;
  localparam logic [1:0] SEL_VOLUME = 2'd2;
  localparam logic [1:0] SEL_ENABLE = 2'd3;

  localparam int unsigned DIST_WIDTH = 24;

  // Gain and volume are unsigned 4.20, so unity sits at bit WIDTH-4.
  localparam logic [DIST_WIDTH-1:0] GAIN_UNITY     = 24'h10_0000;
  localparam logic [DIST_WIDTH-1:0] THRESH_MAX     = 24'h7F_FFFF;
  localparam logic [DIST_WIDTH-1:0] VOLUME_DEFAULT = 24'h10_0000;

endpackage

// File: rtl/param_ramp.sv
// One-step ramp: moves current toward target by |diff|>>STEP_SHIFT (at least 1).
module param_ramp #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned STEP_SHIFT = 6
) (
  input  logic [WIDTH-1:0] i_current,
  input  logic [WIDTH-1:0] i_target,
  output logic [WIDTH-1:0] o_next,
  output logic             o_at_target
);

  logic             w_up;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_step;

  always_comb begin
    w_up        = i_target > i_current;
    w_diff      = w_up ? (i_target - i_current) : (i_current - i_target);
    w_step      = w_diff >> STEP_SHIFT;
    if (w_step == '0) begin
      w_step = WIDTH'(1);
    end
    o_at_target = (w_diff == '0);
    // step never exceeds diff, so neither overshoot nor wrap can occur
    if (o_at_target) begin
      o_next = i_current;
    end else if (w_up) begin
      o_next = i_current + w_step;
    end else begin
      o_next = i_current - w_step;
    end
  end

endmodule

// File: rtl/distortion_param_ctrl.sv
// Zipper-free parameter sequencer with click-free enable fades.
// Optional tick watchdog enabled by defining DIST_TICK_WATCHDOG_EN.
module distortion_param_ctrl
  import distortion_pkg::*;
#(
  parameter int unsigned WIDTH        = DIST_WIDTH,
  parameter int unsigned STEP_SHIFT   = 6
`ifdef DIST_TICK_WATCHDOG_EN
  ,
  parameter int unsigned TICK_TIMEOUT = 4096
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sample_tick,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [1:0]       i_cfg_sel,
  input  logic [WIDTH-1:0] i_cfg_data,
  output logic [WIDTH-1:0] o_gain_out,
  output logic [WIDTH-1:0] o_threshold_out,
  output logic [WIDTH-1:0] o_volume_out,
  output logic             o_enable_out,
  output logic             o_busy
`ifdef DIST_TICK_WATCHDOG_EN
  ,
  output logic             o_tick_timeout
`endif
);

  localparam logic [WIDTH-1:0] LP_GAIN_RST   = WIDTH'(GAIN_UNITY);
  localparam logic [WIDTH-1:0] LP_THRESH_RST = WIDTH'(THRESH_MAX);
  localparam logic [WIDTH-1:0] LP_VOL_RST    = WIDTH'(VOLUME_DEFAULT);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_gain, r_gain_tgt, r_thresh, r_thresh_tgt, r_vol, r_vol_tgt;
  logic             r_enable, r_enable_tgt;

  logic [WIDTH-1:0] w_gain_next, w_thresh_next, w_vol_next, w_vol_ramp_tgt;
  logic [WIDTH-1:0] w_gain_d, w_thresh_d, w_vol_d;
  logic             w_gain_at, w_thresh_at, w_vol_at, w_all_at;
  logic             w_wr, w_en_toggle, w_wd_fire;

  assign o_cfg_ready     = (r_state == StIdle) || (r_state == StRamp);
  assign o_busy          = (r_state != StIdle);
  assign o_gain_out      = r_gain;
  assign o_threshold_out = r_thresh;
  assign o_volume_out    = r_vol;
  assign o_enable_out    = r_enable;

  assign w_wr        = i_cfg_valid && o_cfg_ready;
  assign w_en_toggle = w_wr && (i_cfg_sel == SEL_ENABLE) && (i_cfg_data[0] != r_enable);

  // Volume heads for silence while fading out; its stored target stays untouched.
  assign w_vol_ramp_tgt = ((r_state == StFadeOut) || (r_state == StSwitch)) ? '0 : r_vol_tgt;

  param_ramp #(.WIDTH(WIDTH), .STEP_SHIFT(STEP_SHIFT)) u_ramp_gain (
    .i_current  (r_gain),
    .i_target   (r_gain_tgt),
    .o_next     (w_gain_next),
    .o_at_target(w_gain_at)
  );

  param_ramp #(.WIDTH(WIDTH), .STEP_SHIFT(STEP_SHIFT)) u_ramp_thresh (
    .i_current  (r_thresh),
    .i_target   (r_thresh_tgt),
    .o_next     (w_thresh_next),
    .o_at_target(w_thresh_at)
  );

  param_ramp #(.WIDTH(WIDTH), .STEP_SHIFT(STEP_SHIFT)) u_ramp_vol (
    .i_current  (r_vol),
    .i_target   (w_vol_ramp_tgt),
    .o_next     (w_vol_next),
    .o_at_target(w_vol_at)
  );

  assign w_all_at   = w_gain_at && w_thresh_at && w_vol_at;
  assign w_gain_d   = i_sample_tick ? w_gain_next : r_gain;
  assign w_thresh_d = i_sample_tick ? w_thresh_next : r_thresh;
  assign w_vol_d    = i_sample_tick ? w_vol_next : r_vol;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StRamp: begin
        if (w_en_toggle)    w_state_d = StFadeOut;
        else if (!w_all_at) w_state_d = StRamp;
        else                w_state_d = StIdle;
      end
      // Leave on the edge volume lands at zero so enable flips one cycle later.
      StFadeOut: if (w_vol_d == '0) w_state_d = StSwitch;
      StSwitch:  w_state_d = StFadeIn;
      StFadeIn: begin
        if (w_vol_d == r_vol_tgt) begin
          w_state_d = ((w_gain_d == r_gain_tgt) && (w_thresh_d == r_thresh_tgt)) ? StIdle : StRamp;
        end
      end
      default:   w_state_d = StIdle;
    endcase
    if (w_wd_fire) w_state_d = StIdle;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_gain       <= LP_GAIN_RST;
      r_gain_tgt   <= LP_GAIN_RST;
      r_thresh     <= LP_THRESH_RST;
      r_thresh_tgt <= LP_THRESH_RST;
      r_vol        <= LP_VOL_RST;
      r_vol_tgt    <= LP_VOL_RST;
      r_enable     <= 1'b0;
      r_enable_tgt <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_wr && (i_cfg_sel == SEL_GAIN))   r_gain_tgt   <= i_cfg_data;
      if (w_wr && (i_cfg_sel == SEL_THRESH)) r_thresh_tgt <= i_cfg_data;
      if (w_wr && (i_cfg_sel == SEL_VOLUME)) r_vol_tgt    <= i_cfg_data;
      if (w_en_toggle)                       r_enable_tgt <= i_cfg_data[0];
      if (w_wd_fire) begin
        r_gain   <= r_gain_tgt;
        r_thresh <= r_thresh_tgt;
        r_vol    <= r_vol_tgt;
        r_enable <= r_enable_tgt;
      end else begin
        r_gain   <= w_gain_d;
        r_thresh <= w_thresh_d;
        r_vol    <= w_vol_d;
        if (r_state == StSwitch) r_enable <= r_enable_tgt;
      end
    end
  end

`ifdef DIST_TICK_WATCHDOG_EN
  localparam int unsigned LP_WD_W = $clog2(TICK_TIMEOUT + 1);

  logic [LP_WD_W-1:0] r_wd_cnt;
  logic               r_tick_timeout;

  assign w_wd_fire      = o_busy && !i_sample_tick && (r_wd_cnt == LP_WD_W'(TICK_TIMEOUT - 1));
  assign o_tick_timeout = r_tick_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt       <= '0;
      r_tick_timeout <= 1'b0;
    end else begin
      r_tick_timeout <= w_wd_fire;
      if (!o_busy || i_sample_tick || w_wd_fire) r_wd_cnt <= '0;
      else                                       r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_distortion_param_ctrl.sv
// Directed self-checking bench for distortion_param_ctrl.
module tb_distortion_param_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_sel;
  logic [23:0] cfg_data;
  logic [23:0] gain_out, thresh_out, vol_out;
  logic        enable_out, busy;
`ifdef DIST_TICK_WATCHDOG_EN
  logic        tick_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  logic [23:0] g_m, g_t, t_m, t_t, v_m;
  int          n;

  always #5 clk = ~clk;

  distortion_param_ctrl #(
    .WIDTH       (24),
    .STEP_SHIFT  (6)
`ifdef DIST_TICK_WATCHDOG_EN
    ,
    .TICK_TIMEOUT(16)
`endif
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample_tick  (tick),
    .i_cfg_valid    (cfg_valid),
    .o_cfg_ready    (cfg_ready),
    .i_cfg_sel      (cfg_sel),
    .i_cfg_data     (cfg_data),
    .o_gain_out     (gain_out),
    .o_threshold_out(thresh_out),
    .o_volume_out   (vol_out),
    .o_enable_out   (enable_out),
    .o_busy         (busy)
`ifdef DIST_TICK_WATCHDOG_EN
    ,
    .o_tick_timeout (tick_timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ramp(input logic [23:0] cur, input logic [23:0] tgt);
    logic [23:0] diff, step;
    if (cur == tgt) return cur;
    diff = (tgt > cur) ? tgt - cur : cur - tgt;
    step = diff >> 6;
    if (step == 24'd0) step = 24'd1;
    return (tgt > cur) ? cur + step : cur - step;
  endfunction

  task automatic tick_once();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic write_cfg(input logic [1:0] sel, input logic [23:0] data);
    @(negedge clk);
    check("ready_at_write", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_data  = data;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n     = 1'b0;
    tick      = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = 2'd0;
    cfg_data  = 24'd0;
    repeat (2) @(negedge clk);
    check("rst_gain",   32'(gain_out),   32'h10_0000);
    check("rst_thresh", 32'(thresh_out), 32'h7F_FFFF);
    check("rst_vol",    32'(vol_out),    32'h10_0000);
    check("rst_enable", 32'(enable_out), 32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_ready",  32'(cfg_ready),  32'd1);
`ifdef DIST_TICK_WATCHDOG_EN
    check("rst_tick_timeout", 32'(tick_timeout), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Gain ramp up to 0x140000
    g_t = 24'h14_0000;
    write_cfg(2'd0, g_t);
    tick_once();
    check("gain_step1", 32'(gain_out), 32'h10_1000);
    g_m = 24'h10_1000;
    n   = 0;
    while (g_m != g_t && n < 2000) begin
      tick_once();
      g_m = ramp(g_m, g_t);
      check("gain_ramp", 32'(gain_out), 32'(g_m));
      n++;
    end
    check("gain_ramp_bounded", 32'(n < 2000), 32'd1);
    check("gain_settled", 32'(gain_out), 32'h14_0000);
    repeat (2) @(negedge clk);
    check("gain_idle_busy", 32'(busy), 32'd0);

    // Threshold ramp down, with a gain retarget landing on a tick
    t_t = 24'h00_0010;
    write_cfg(2'd1, t_t);
    tick_once();
    check("thresh_step1", 32'(thresh_out), 32'h7E_0000);
    t_m = 24'h7E_0000;
    repeat (3) begin
      tick_once();
      t_m = ramp(t_m, t_t);
      check("thresh_ramp", 32'(thresh_out), 32'(t_m));
    end
    @(negedge clk);
    check("ready_in_ramp", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_sel   = 2'd0;
    cfg_data  = 24'h08_0000;
    tick      = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    tick      = 1'b0;
    t_m = ramp(t_m, t_t);
    check("thresh_same_tick", 32'(thresh_out), 32'(t_m));
    check("gain_old_target",  32'(gain_out),   32'h14_0000);
    g_t = 24'h08_0000;
    tick_once();
    t_m = ramp(t_m, t_t);
    check("gain_retarget", 32'(gain_out), 32'h13_D000);
    g_m = 24'h13_D000;
    n   = 0;
    while ((g_m != g_t || t_m != t_t) && n < 3000) begin
      tick_once();
      g_m = ramp(g_m, g_t);
      t_m = ramp(t_m, t_t);
      check("gain_ramp2",   32'(gain_out),   32'(g_m));
      check("thresh_ramp2", 32'(thresh_out), 32'(t_m));
      n++;
    end
    check("ramp2_bounded",  32'(n < 3000),   32'd1);
    check("thresh_settled", 32'(thresh_out), 32'h00_0010);
    check("gain_settled2",  32'(gain_out),   32'h08_0000);
    repeat (2) @(negedge clk);
    check("ramp2_idle_busy", 32'(busy), 32'd0);

    // Enable on: fade out, switch, fade in
    write_cfg(2'd3, 24'd1);
    check("fade_ready", 32'(cfg_ready), 32'd0);
    check("fade_busy",  32'(busy),      32'd1);
    v_m = 24'h10_0000;
    n   = 0;
    while (v_m != 24'd0 && n < 2000) begin
      tick_once();
      v_m = ramp(v_m, 24'd0);
      check("fade_out_vol", 32'(vol_out), 32'(v_m));
      if (v_m == 24'd0) check("enable_before_switch", 32'(enable_out), 32'd0);
      n++;
    end
    check("fade_out_bounded", 32'(n < 2000), 32'd1);
    @(negedge clk);
    check("enable_after_switch", 32'(enable_out), 32'd1);
    check("switch_vol_zero",     32'(vol_out),    32'd0);
    check("fade_in_ready",       32'(cfg_ready),  32'd0);
    n = 0;
    while (v_m != 24'h10_0000 && n < 2000) begin
      tick_once();
      v_m = ramp(v_m, 24'h10_0000);
      check("fade_in_vol", 32'(vol_out), 32'(v_m));
      n++;
    end
    check("fade_in_bounded", 32'(n < 2000), 32'd1);
    check("fade_done_busy",  32'(busy),      32'd0);
    check("fade_done_ready", 32'(cfg_ready), 32'd1);
    check("fade_done_en",    32'(enable_out), 32'd1);

    // Same-value enable write is ignored
    write_cfg(2'd3, 24'd1);
    repeat (3) @(negedge clk);
    check("same_en_busy", 32'(busy),       32'd0);
    check("same_en_vol",  32'(vol_out),    32'h10_0000);
    check("same_en_en",   32'(enable_out), 32'd1);

    // Reset during fade out
    write_cfg(2'd3, 24'd0);
    v_m = 24'h10_0000;
    repeat (3) begin
      tick_once();
      v_m = ramp(v_m, 24'd0);
    end
    check("pre_reset_vol",  32'(vol_out), 32'(v_m));
    check("pre_reset_busy", 32'(busy),    32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midfade_rst_gain",   32'(gain_out),   32'h10_0000);
    check("midfade_rst_thresh", 32'(thresh_out), 32'h7F_FFFF);
    check("midfade_rst_vol",    32'(vol_out),    32'h10_0000);
    check("midfade_rst_en",     32'(enable_out), 32'd0);
    check("midfade_rst_busy",   32'(busy),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick_once();
    check("post_rst_en",   32'(enable_out), 32'd0);
    check("post_rst_busy", 32'(busy),       32'd0);
    check("post_rst_vol",  32'(vol_out),    32'h10_0000);

`ifdef DIST_TICK_WATCHDOG_EN
    begin
      int pulses;
      pulses = 0;
      write_cfg(2'd2, 24'd0);
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (tick_timeout) pulses++;
      end
      check("wd_pulses", 32'(pulses),  32'd1);
      check("wd_vol",    32'(vol_out), 32'd0);
      check("wd_busy",   32'(busy),    32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
